// File: rtl/mem_cycle_gen_pkg.sv
// Shared definitions for the expansion-bus cycle sequencer.
// Holds the state encoding, counter widths and the phase reload helper.
package mem_cycle_gen_pkg;

  localparam int PHASE_W = 4;
  localparam int WS_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // A phase of N cycles loads N-1 so the zero flag marks its last cycle.
  function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
    return (cycles > 0) ? PHASE_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 4-bit down-counter with a zero flag, shared by every bus phase.
// Latency: load takes effect on the next clk edge; zero is combinational from the count.
// Backpressure: none; the counter parks at zero until reloaded.
module phase_timer
  import mem_cycle_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  output logic               zero
);

  logic [PHASE_W-1:0] cnt_q;
  logic [PHASE_W-1:0] cnt_d;

  // Reload on request, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_cycle_gen.sv
// Single-word bus-cycle sequencer driving SRAM-style strobes with setup/strobe/hold phases.
// Latency: ack arrives 1 + SETUP + STROBE + waits + HOLD cycles after the accepting edge.
// Backpressure: req is only sampled in IDLE (including the ack cycle); ec_nws stretches STROBE.
module mem_cycle_gen
  import mem_cycle_gen_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int WS_MAX        = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        io,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] ec_ab,
  inout  wire  [15:0] ec_db,
  output logic        ec_nmem,
  output logic        ec_nio,
  output logic        ec_nr,
  output logic        ec_nw,
  input  logic        ec_nws
);

  localparam logic [PHASE_W-1:0] SETUP_LD  = phase_load(SETUP_CYCLES);
  localparam logic [PHASE_W-1:0] STROBE_LD = phase_load(STROBE_CYCLES);
  localparam logic [PHASE_W-1:0] HOLD_LD   = phase_load(HOLD_CYCLES);
  localparam logic [WS_W-1:0]    WS_LIM    = WS_W'(WS_MAX);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              io_q, io_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [WS_W-1:0]   ws_cnt_q, ws_cnt_d;
  logic              tmo_q, tmo_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              nmem_q, nmem_d;
  logic              nio_q, nio_d;
  logic              nr_q, nr_d;
  logic              nw_q, nw_d;
  logic              db_oe_q, db_oe_d;

  logic              ph_load;
  logic [PHASE_W-1:0] ph_val;
  logic              ph_zero;
  logic              strobe_on;

  phase_timer u_phase_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  // Next-state, latch, wait-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    io_d     = io_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ws_cnt_d = ws_cnt_q;
    tmo_d    = tmo_q;
    ph_load  = 1'b0;
    ph_val   = STROBE_LD;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d     = we;
          io_d     = io;
          addr_d   = addr;
          wdata_d  = wdata;
          ws_cnt_d = '0;
          tmo_d    = 1'b0;
          state_d  = (SETUP_CYCLES > 0) ? ST_SETUP : ST_STROBE;
        end
      end
      ST_SETUP: begin
        if (ph_zero) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        // Wait request only matters once the programmed strobe time has elapsed.
        if (ph_zero) begin
          if (!ec_nws && (ws_cnt_q != WS_LIM)) begin
            ws_cnt_d = ws_cnt_q + 1'b1;
          end else begin
            if (!ec_nws) tmo_d = 1'b1;
            if (!we_q) rdata_d = ec_db;
            state_d = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (ph_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timer is reloaded on entry to each timed phase.
    if ((state_d != state_q) && (state_d != ST_IDLE)) begin
      ph_load = 1'b1;
      case (state_d)
        ST_SETUP: ph_val = SETUP_LD;
        ST_HOLD:  ph_val = HOLD_LD;
        default:  ph_val = STROBE_LD;
      endcase
    end

    ack_d     = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    err_d     = ack_d && tmo_d;
    busy_d    = (state_d != ST_IDLE);
    strobe_on = (state_d == ST_STROBE);
    nmem_d    = !(strobe_on && !io_d);
    nio_d     = !(strobe_on && io_d);
    nr_d      = !(strobe_on && !we_d);
    nw_d      = !(strobe_on && we_d);
    db_oe_d   = busy_d && we_d;
  end

  // State, latches and registered bus outputs; reset forces strobes idle and releases ec_db.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ws_cnt_q <= '0;
      tmo_q    <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      nmem_q   <= 1'b1;
      nio_q    <= 1'b1;
      nr_q     <= 1'b1;
      nw_q     <= 1'b1;
      db_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      io_q     <= io_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ws_cnt_q <= ws_cnt_d;
      tmo_q    <= tmo_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      nmem_q   <= nmem_d;
      nio_q    <= nio_d;
      nr_q     <= nr_d;
      nw_q     <= nw_d;
      db_oe_q  <= db_oe_d;
    end
  end

  assign busy    = busy_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign ec_ab   = addr_q;
  assign ec_db   = db_oe_q ? wdata_q : 16'hzzzz;
  assign ec_nmem = nmem_q;
  assign ec_nio  = nio_q;
  assign ec_nr   = nr_q;
  assign ec_nw   = nw_q;

endmodule

// File: tb/tb_mem_cycle_gen.sv
module tb_mem_cycle_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        io = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        busy, ack, err;
  logic [15:0] rdata, ec_ab;
  wire  [15:0] ec_db;
  logic        ec_nmem, ec_nio, ec_nr, ec_nw;
  logic        ec_nws = 1'b1;

  int passed = 0;
  int total  = 0;

  // Transaction observation results.
  int   r_ack_cyc, r_nr_lo, r_nw_lo, r_nmem_lo, r_nio_lo, r_both, r_ab_bad, r_db_bad, r_mem_oe;
  logic r_err;

  always #5 clk = ~clk;

  mem_cycle_gen #(
    .SETUP_CYCLES (1),
    .STROBE_CYCLES(2),
    .HOLD_CYCLES  (1),
    .WS_MAX       (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .io     (io),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .ack    (ack),
    .err    (err),
    .rdata  (rdata),
    .ec_ab  (ec_ab),
    .ec_db  (ec_db),
    .ec_nmem(ec_nmem),
    .ec_nio (ec_nio),
    .ec_nr  (ec_nr),
    .ec_nw  (ec_nw),
    .ec_nws (ec_nws)
  );

  // 64 kW SRAM model: drives on memory reads, captures mid-cycle on memory writes.
  logic [15:0] mem [0:65535];
  logic        mem_oe;
  assign mem_oe = !ec_nmem && !ec_nr;
  assign ec_db  = mem_oe ? mem[ec_ab] : 16'hzzzz;
  always @(negedge clk) if (!ec_nmem && !ec_nw) mem[ec_ab] <= ec_db;

  // Issue one request and watch it until ack; ec_nws is low at the end of cycles [ws_from, ws_from+ws_len).
  task automatic run_txn(input logic t_we, input logic t_io, input logic [15:0] t_addr,
                         input logic [15:0] t_wdata, input int ws_from, input int ws_len);
    r_ack_cyc = -1; r_nr_lo = 0; r_nw_lo = 0; r_nmem_lo = 0; r_nio_lo = 0;
    r_both = 0; r_ab_bad = 0; r_db_bad = 0; r_mem_oe = 0; r_err = 1'b0;
    @(negedge clk);
    req = 1'b1; we = t_we; io = t_io; addr = t_addr; wdata = t_wdata; ec_nws = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~t_we; io = ~t_io; addr = ~t_addr; wdata = ~t_wdata;
    for (int c = 1; c <= 40 && r_ack_cyc < 0; c++) begin
      @(negedge clk);
      if (ack) begin
        r_ack_cyc = c;
        r_err = err;
      end else begin
        if (!ec_nr)   r_nr_lo++;
        if (!ec_nw)   r_nw_lo++;
        if (!ec_nmem) r_nmem_lo++;
        if (!ec_nio)  r_nio_lo++;
        if ((!ec_nmem && !ec_nio) || (!ec_nr && !ec_nw)) r_both++;
        if (ec_ab !== t_addr) r_ab_bad++;
        if (t_we && (ec_db !== t_wdata)) r_db_bad++;
        if (mem_oe) r_mem_oe++;
      end
      ec_nws = !((c >= ws_from) && (c < ws_from + ws_len));
    end
    ec_nws = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (ec_nmem !== 1'b1) $display("FAIL reset_nmem: got %0b want 1", ec_nmem); else passed++;
    total++; if (ec_nio !== 1'b1)  $display("FAIL reset_nio: got %0b want 1", ec_nio); else passed++;
    total++; if (ec_nr !== 1'b1)   $display("FAIL reset_nr: got %0b want 1", ec_nr); else passed++;
    total++; if (ec_nw !== 1'b1)   $display("FAIL reset_nw: got %0b want 1", ec_nw); else passed++;
    total++; if (ec_ab !== 16'h0)  $display("FAIL reset_ab: got %h want 0000", ec_ab); else passed++;
    total++; if (rdata !== 16'h0)  $display("FAIL reset_rdata: got %h want 0000", rdata); else passed++;
    total++; if ({ack, err, busy} !== 3'b000) $display("FAIL reset_ack_err_busy: got %b want 000", {ack, err, busy}); else passed++;
    total++; if (dut.db_oe_q !== 1'b0) $display("FAIL reset_db_release: got %0b want 0", dut.db_oe_q); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    run_txn(1'b1, 1'b0, 16'hBEEF, 16'h1234, 0, 0);
    total++; if (r_ack_cyc != 5)  $display("FAIL wr_ack_cycle: got %0d want 5", r_ack_cyc); else passed++;
    total++; if (r_nw_lo != 2)    $display("FAIL wr_nw_low: got %0d want 2", r_nw_lo); else passed++;
    total++; if (r_nr_lo != 0)    $display("FAIL wr_nr_low: got %0d want 0", r_nr_lo); else passed++;
    total++; if (r_nmem_lo != 2)  $display("FAIL wr_nmem_low: got %0d want 2", r_nmem_lo); else passed++;
    total++; if (r_ab_bad != 0 || r_db_bad != 0) $display("FAIL wr_bus_stable: got ab_bad=%0d db_bad=%0d want 0/0", r_ab_bad, r_db_bad); else passed++;
    total++; if (r_err !== 1'b0)  $display("FAIL wr_err: got %0b want 0", r_err); else passed++;
    total++; if (mem[16'hBEEF] !== 16'h1234) $display("FAIL wr_mem: got %h want 1234", mem[16'hBEEF]); else passed++;
    @(negedge clk);
    total++; if (ack !== 1'b0) $display("FAIL wr_ack_pulse: got %0b want 0", ack); else passed++;
    run_txn(1'b0, 1'b0, 16'hBEEF, 16'h0000, 0, 0);
    total++; if (r_ack_cyc != 5)  $display("FAIL rd_ack_cycle: got %0d want 5", r_ack_cyc); else passed++;
    total++; if (r_nr_lo != 2 || r_nw_lo != 0) $display("FAIL rd_strobes: got nr=%0d nw=%0d want 2/0", r_nr_lo, r_nw_lo); else passed++;
    total++; if (rdata !== 16'h1234) $display("FAIL rd_data: got %h want 1234", rdata); else passed++;
  endtask

  task automatic test_wait_states();
    run_txn(1'b0, 1'b0, 16'hBEEF, 16'h0000, 3, 3);
    total++; if (r_nr_lo != 5)   $display("FAIL ws_strobe_len: got %0d want 5", r_nr_lo); else passed++;
    total++; if (r_ack_cyc != 8) $display("FAIL ws_ack_cycle: got %0d want 8", r_ack_cyc); else passed++;
    total++; if (r_err !== 1'b0) $display("FAIL ws_err: got %0b want 0", r_err); else passed++;
    total++; if (rdata !== 16'h1234) $display("FAIL ws_rdata: got %h want 1234", rdata); else passed++;
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 1, 1000);
    total++; if (r_nr_lo != 6)   $display("FAIL tmo_strobe_len: got %0d want 6", r_nr_lo); else passed++;
    total++; if (r_ack_cyc != 9) $display("FAIL tmo_ack_cycle: got %0d want 9", r_ack_cyc); else passed++;
    total++; if (r_err !== 1'b1) $display("FAIL tmo_err: got %0b want 1", r_err); else passed++;
    @(negedge clk);
    total++; if ({ack, err} !== 2'b00) $display("FAIL tmo_pulse: got %b want 00", {ack, err}); else passed++;
  endtask

  task automatic test_io();
    run_txn(1'b1, 1'b0, 16'h0102, 16'hAAAA, 0, 0);
    total++; if (mem[16'h0102] !== 16'hAAAA) $display("FAIL io_preload: got %h want aaaa", mem[16'h0102]); else passed++;
    run_txn(1'b0, 1'b1, 16'h0102, 16'h0000, 0, 0);
    total++; if (r_nio_lo != 2)  $display("FAIL io_nio_low: got %0d want 2", r_nio_lo); else passed++;
    total++; if (r_nmem_lo != 0) $display("FAIL io_nmem_low: got %0d want 0", r_nmem_lo); else passed++;
    total++; if (r_mem_oe != 0)  $display("FAIL io_mem_drive: got %0d want 0", r_mem_oe); else passed++;
    total++; if (r_both != 0)    $display("FAIL io_exclusive: got %0d want 0", r_both); else passed++;
    total++; if (r_ack_cyc != 5) $display("FAIL io_ack_cycle: got %0d want 5", r_ack_cyc); else passed++;
    total++; if (rdata === 16'hAAAA) $display("FAIL io_rdata: got %h want not aaaa", rdata); else passed++;
  endtask

  task automatic test_back_to_back();
    int a1, a2, gap_bad;
    logic [15:0] ab3, ab7;
    logic busy5, busy6;
    a1 = -1; a2 = -1; gap_bad = 0; ab3 = '0; ab7 = '0; busy5 = 1'b1; busy6 = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; io = 1'b0; addr = 16'h0300; wdata = 16'h5A5A;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack && a1 < 0) a1 = c;
      else if (ack && a2 < 0) a2 = c;
      if ((c == 4 || c == 5) && ({ec_nmem, ec_nio, ec_nr, ec_nw} !== 4'b1111)) gap_bad++;
      if (c == 3) ab3 = ec_ab;
      if (c == 7) ab7 = ec_ab;
      if (c == 5) busy5 = busy;
      if (c == 6) busy6 = busy;
      if (c == 2) begin addr = 16'h0301; we = 1'b0; wdata = 16'hFFFF; end
      if (c == 5) addr = 16'h0300;
      if (c == 6) req = 1'b0;
    end
    total++; if (a1 != 5)  $display("FAIL b2b_ack1: got %0d want 5", a1); else passed++;
    total++; if (a2 != 10) $display("FAIL b2b_ack2: got %0d want 10", a2); else passed++;
    total++; if (gap_bad != 0) $display("FAIL b2b_strobe_gap: got %0d want 0", gap_bad); else passed++;
    total++; if (ab3 !== 16'h0300) $display("FAIL b2b_addr_ignored: got %h want 0300", ab3); else passed++;
    total++; if (ab7 !== 16'h0300) $display("FAIL b2b_addr2: got %h want 0300", ab7); else passed++;
    total++; if (busy5 !== 1'b0 || busy6 !== 1'b1) $display("FAIL b2b_busy: got %b%b want 01", busy5, busy6); else passed++;
    total++; if (mem[16'h0300] !== 16'h5A5A) $display("FAIL b2b_mem: got %h want 5a5a", mem[16'h0300]); else passed++;
    total++; if (rdata !== 16'h5A5A) $display("FAIL b2b_rdata: got %h want 5a5a", rdata); else passed++;
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; io = 1'b0; addr = 16'h0400; wdata = 16'h7777;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (ec_nw !== 1'b0) $display("FAIL rst_mid_in_strobe: got %0b want 0", ec_nw); else passed++;
    #1 reset = 1'b1;
    #1;
    total++; if ({ec_nmem, ec_nio, ec_nr, ec_nw} !== 4'b1111) $display("FAIL rst_mid_strobes: got %b want 1111", {ec_nmem, ec_nio, ec_nr, ec_nw}); else passed++;
    total++; if (dut.db_oe_q !== 1'b0) $display("FAIL rst_mid_db_release: got %0b want 0", dut.db_oe_q); else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    total++; if (acks != 0) $display("FAIL rst_mid_no_ack: got %0d want 0", acks); else passed++;
    total++; if (rdata !== 16'h0) $display("FAIL rst_mid_rdata: got %h want 0000", rdata); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %0b want 0", busy); else passed++;
    run_txn(1'b0, 1'b0, 16'hBEEF, 16'h0000, 0, 0);
    total++; if (r_ack_cyc != 5) $display("FAIL rst_mid_next_ack: got %0d want 5", r_ack_cyc); else passed++;
    total++; if (rdata !== 16'h1234) $display("FAIL rst_mid_next_rdata: got %h want 1234", rdata); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_io();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
